// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and word geometry.
package lsu_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake between core and LSU, plus the LSU-to-RAM word bus.
interface mem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;
    logic [31:0] mem_adr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_wen, mem_adr, mem_din,
        input  mem_dout
    );

    modport ram (
        input  mem_wen, mem_adr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts/extends load data and merges sub-word store data into a word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];
        rdata_o  = word_i;
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                rdata_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                rdata_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                rdata_o  = word_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a single-port word RAM; sub-word stores are done as read-modify-write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses instead of clearing low bits.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [2:0]       state_q, state_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] mem_din_q, mem_din_d;
    logic [31:0]      mem_adr_q, mem_adr_d;

    logic [31:0]      word_idx;
    logic [1:0]       req_off;
    logic             base_err;
    logic             req_err;
    logic [WIDTH-1:0] lane_word;
    logic [WIDTH-1:0] lane_rdata;
    logic [WIDTH-1:0] lane_merged;

    assign word_idx = bus.req_addr >> WORD_SHIFT;
    assign base_err = (bus.req_size == SZ_ILL) || (word_idx >= DEPTH_U);

    // Halfword/word offsets are forced aligned; with the check enabled a misaligned request never gets this far.
    always_comb begin
        req_off = bus.req_addr[1:0];
        case (bus.req_size)
            SZ_HALF: req_off = {bus.req_addr[1], 1'b0};
            SZ_WORD: req_off = 2'b00;
            default: req_off = bus.req_addr[1:0];
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign req_err  = base_err || misalign;
`else
    assign req_err  = base_err;
`endif

    // In RD the lane merges against the live RAM word; otherwise it extracts from the captured word.
    assign lane_word = (state_q == RD) ? bus.mem_dout : word_q;

    lsu_lane u_lane (
        .word_i     (lane_word),
        .wdata_i    (wdata_q),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rdata_o    (lane_rdata),
        .merged_o   (lane_merged)
    );

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        word_d    = word_q;
        mem_adr_d = mem_adr_q;
        mem_din_d = mem_din_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d   = req_off;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    if (req_err) begin
                        state_d = ERR;
                    end else begin
                        mem_adr_d = word_idx;
                        if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            mem_din_d = bus.req_wdata;
                            state_d   = WR;
                        end else begin
                            state_d   = RD;
                        end
                    end
                end
            end
            RD: begin
                word_d = bus.mem_dout;
                if (we_q) begin
                    mem_din_d = lane_merged;
                    state_d   = WR;
                end else begin
                    state_d   = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            word_q    <= '0;
            mem_adr_q <= '0;
            mem_din_q <= '0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            word_q    <= word_d;
            mem_adr_q <= mem_adr_d;
            mem_din_q <= mem_din_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP) || (state_q == ERR);
    assign bus.resp_err   = (state_q == ERR);
    assign bus.resp_rdata = ((state_q == RESP) && !we_q) ? lane_rdata : '0;
    assign bus.mem_wen    = (state_q == WR);
    assign bus.mem_adr    = mem_adr_q;
    assign bus.mem_din    = mem_din_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a behavioural 128-word RAM and a standalone lane check.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu #(.DEPTH(128), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] laneWord, laneWdata, laneRdata, laneMerged;
    logic [1:0]  laneOff, laneSize;
    logic        laneUns;

    lsu_lane u_laneTb (
        .word_i     (laneWord),
        .wdata_i    (laneWdata),
        .off_i      (laneOff),
        .size_i     (laneSize),
        .unsigned_i (laneUns),
        .rdata_o    (laneRdata),
        .merged_o   (laneMerged)
    );

    logic [31:0] ram [0:127];
    logic        ramClear;
    logic        preEn;
    logic [6:0]  preIdx;
    logic [31:0] preData;
    int          wenCount = 0;
    logic [31:0] lastWrAdr = '0;
    logic [31:0] lastWrDin = '0;

    // Behavioural RAM: combinational read, posedge write, plus a preload path for the bench.
    always @(posedge clk) begin
        if (ramClear) begin
            for (int i = 0; i < 128; i++) ram[i] <= '0;
        end else if (preEn) begin
            ram[preIdx] <= preData;
        end else if (bus.mem_wen && (bus.mem_adr < 32'd128)) begin
            ram[bus.mem_adr[6:0]] <= bus.mem_din;
        end
        if (bus.mem_wen) begin
            wenCount  <= wenCount + 1;
            lastWrAdr <= bus.mem_adr;
            lastWrDin <= bus.mem_din;
        end
    end

    assign bus.mem_dout = (bus.mem_adr < 32'd128) ? ram[bus.mem_adr[6:0]] : 32'h0;

    int          errors = 0;
    int          checks = 0;
    int          respLat;
    logic [31:0] respData;
    logic        respErr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        preIdx  = idx;
        preData = data;
        preEn   = 1'b1;
        @(posedge clk); #1;
        preEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        checkOutput("ready_in_idle", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        respLat = 1;
        while (!bus.resp_valid && respLat < 8) begin
            @(posedge clk); #1;
            respLat++;
        end
        respData = bus.resp_rdata;
        respErr  = bus.resp_err;
    endtask

    task automatic checkResp(input string tag, input int lat, input logic err, input logic [31:0] data);
        checkOutput({tag, "_lat"}, 32'(respLat), 32'(lat));
        checkOutput({tag, "_err"}, {31'b0, respErr}, {31'b0, err});
        checkOutput({tag, "_data"}, respData, data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          wb;
        int          accCount;
        int          pulses;
        logic        prevReady;
        logic [31:0] b2bData [3];
        int          b2bPulse [3];
        logic        expReady;

        rst              = 1'b1;
        ramClear         = 1'b1;
        preEn            = 1'b0;
        preIdx           = '0;
        preData          = '0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        laneWord  = 32'h80FF7F01;
        laneWdata = 32'h000000AB;
        laneOff   = 2'd2;
        laneSize  = SZ_HALF;
        laneUns   = 1'b0;
        #1;
        checkOutput("lane_lh_upper", laneRdata, 32'hFFFF80FF);
        laneWord = 32'h11223344;
        laneOff  = 2'd1;
        laneSize = SZ_BYTE;
        #1;
        checkOutput("lane_merge_byte1", laneMerged, 32'h1122AB44);
        checkOutput("lane_lb_byte1", laneRdata, 32'h00000033);

        @(posedge clk); #1;
        ramClear = 1'b0;
        checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        checkOutput("rst_mem_wen", {31'b0, bus.mem_wen}, 32'd0);
        checkOutput("rst_mem_adr", bus.mem_adr, 32'd0);
        checkOutput("rst_mem_din", bus.mem_din, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        wb = wenCount;
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        checkResp("sw_10", 2, 1'b0, 32'h0);
        checkOutput("sw_10_wen_once", 32'(wenCount - wb), 32'd1);
        checkOutput("sw_10_adr", lastWrAdr, 32'd4);
        checkOutput("sw_10_din", lastWrDin, 32'hDEADBEEF);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        checkResp("lw_10", 2, 1'b0, 32'hDEADBEEF);

        preload(7'd4, 32'h11223344);
        wb = wenCount;
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h000000A5);
        checkResp("sb_13", 3, 1'b0, 32'h0);
        checkOutput("sb_13_wen_once", 32'(wenCount - wb), 32'd1);
        checkOutput("sb_13_ram", ram[4], 32'hA5223344);
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
        checkResp("lb_13", 2, 1'b0, 32'hFFFFFFA5);
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
        checkResp("lbu_13", 2, 1'b0, 32'h000000A5);
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0);
        checkResp("lb_10", 2, 1'b0, 32'h00000044);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
        checkResp("lh_12", 2, 1'b0, 32'hFFFFA522);

        applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00008001);
        checkResp("sh_22", 3, 1'b0, 32'h0);
        checkOutput("sh_22_ram", ram[8], 32'h80010000);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0);
        checkResp("lh_22", 2, 1'b0, 32'hFFFF8001);
        applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0);
        checkResp("lhu_22", 2, 1'b0, 32'h00008001);
        applyStimulus(1'b0, SZ_WORD, 1'b1, 32'h20, 32'h0);
        checkResp("lw_20", 2, 1'b0, 32'h80010000);

        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h1FC, 32'h12345678);
        checkResp("sw_last", 2, 1'b0, 32'h0);
        checkOutput("sw_last_ram", ram[127], 32'h12345678);
        wb = wenCount;
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0);
        checkResp("lw_oob", 1, 1'b1, 32'h0);
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h200, 32'hFFFFFFFF);
        checkResp("sw_oob", 1, 1'b1, 32'h0);
        applyStimulus(1'b0, SZ_ILL, 1'b0, 32'h0, 32'h0);
        checkResp("size_ill", 1, 1'b1, 32'h0);
        checkOutput("err_no_wen", 32'(wenCount - wb), 32'd0);

        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h06, 32'hCAFEF00D);
`ifdef LSU_ALIGN_CHECK_EN
        checkResp("sw_misalign", 1, 1'b1, 32'h0);
        checkOutput("sw_misalign_ram", ram[1], 32'h0);
`else
        checkResp("sw_misalign", 2, 1'b0, 32'h0);
        checkOutput("sw_misalign_ram", ram[1], 32'hCAFEF00D);
`endif

        preload(7'd5, 32'h55667788);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 32'h15;
        bus.req_wdata = 32'h00000099;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("rmw_in_wr", {31'b0, bus.mem_wen}, 32'd1);
        wb = wenCount;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rmw_rst_wen", {31'b0, bus.mem_wen}, 32'd0);
        checkOutput("rmw_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rmw_rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("rmw_rst_mem_adr", bus.mem_adr, 32'd0);
        checkOutput("rmw_rst_mem_din", bus.mem_din, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rmw_rst_no_write", 32'(wenCount - wb), 32'd0);
        checkOutput("rmw_rst_ram", ram[5], 32'h55667788);
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
        checkResp("lw_after_rst", 2, 1'b0, 32'h55667788);

        preload(7'd10, 32'hAAAA0001);
        preload(7'd11, 32'hBBBB0002);
        preload(7'd12, 32'hCCCC0003);
        b2bData  = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
        b2bPulse = '{2, 5, 8};
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h28;
        accCount  = 0;
        pulses    = 0;
        prevReady = bus.req_ready;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (prevReady && bus.req_valid) begin
                accCount++;
                if (accCount < 3) bus.req_addr = 32'h28 + 32'(4 * accCount);
                else bus.req_valid = 1'b0;
            end
            expReady = (c == 3) || (c == 6) || (c >= 9);
            checkOutput($sformatf("b2b_ready_c%0d", c), {31'b0, bus.req_ready}, {31'b0, expReady});
            if (bus.resp_valid) begin
                if (pulses < 3) begin
                    checkOutput($sformatf("b2b_pulse%0d_cycle", pulses), 32'(c), 32'(b2bPulse[pulses]));
                    checkOutput($sformatf("b2b_pulse%0d_data", pulses), bus.resp_rdata, b2bData[pulses]);
                end else begin
                    checkOutput("b2b_extra_pulse", 32'(c), 32'd0);
                end
                pulses++;
            end
            prevReady = bus.req_ready;
        end
        checkOutput("b2b_accepts", 32'(accCount), 32'd3);
        checkOutput("b2b_pulses", 32'(pulses), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit: the initiator side of the word-wide data RAM (single-port; posedge write via wen; combinational read dout = mem[adr]).
- Accepts byte, halfword and word load/store requests from the core datapath over a valid/ready handshake.
- Translates byte addresses to word indices and returns sign- or zero-extended load data.
- RAM has no byte enables, so sub-word stores are performed as read-modify-write.

Parameters:
- DEPTH, 128, number of 32-bit words in the attached RAM; word indices >= DEPTH are out of range.
- WIDTH, 32, data width; fixed at 32, the only supported value.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid: request was rejected, no RAM write occurred
- mem_wen  out  1  RAM write enable
- mem_adr  out  32  RAM word index = req_addr >> 2, zero-extended
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data, combinational from mem_adr

Behaviour:
- Reset values: state IDLE, all internal registers 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_adr=0, mem_din=0.
- Reset is asynchronous. Asserting it mid-operation, including in WR, drops mem_wen the same instant; no partial write may occur after reset assertion.
- mem_wen is decoded purely from state (high only in WR). mem_adr and mem_din are registered; no combinational path runs from req_* to mem_*.
- Acceptance: req_valid && req_ready at a rising edge latches addr, size, unsigned, we and wdata.
- A request is an error if req_size==11, (addr>>2) >= DEPTH, or (with LSU_ALIGN_CHECK_EN) it is misaligned.
- States and transitions:
  - IDLE -> ERR on error.
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for a word store.
  - RD: capture mem_dout into word_q at the edge. A load then goes to RESP; a sub-word store goes to WR with mem_din = merged word.
  - WR: mem_wen=1 for exactly one cycle, then RESP.
  - RESP: resp_valid=1 (with resp_err=0) for one cycle, then IDLE.
  - ERR: resp_valid=1 and resp_err=1 for one cycle, then IDLE.
- Latency, counted in cycles from the accept edge to resp_valid high:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 1.
- Throughput: one request in flight. req_ready=0 in every state except IDLE, and the next acceptance can happen the cycle after RESP or ERR.
- Lane mapping is little-endian: byte lane b = addr[1:0] occupies bits 8b+7:8b; halfword lane addr[1] occupies bits 16*addr[1]+15:16*addr[1].
- Load extraction: select the lane, then sign-extend from bit 7 or 15, or zero-extend if req_unsigned was set. req_unsigned is ignored for word loads.
- Store merge: replace only the addressed lane of word_q with the low bits of wdata; all other lanes are preserved bit-exactly.
- Boundaries:
  - Word index DEPTH-1 is legal; DEPTH is an error.
  - req_valid held high through RESP is not accepted until IDLE.
  - req_* changes while busy are ignored.

Optional Feature:
- LSU_ALIGN_CHECK_EN defined: a halfword with addr[0]!=0, or a word with addr[1:0]!=0, is an error (resp_err=1, no RAM access).
- Not defined: misaligned low address bits are silently cleared (halfword addr[0]=0, word addr[1:0]=0) and the access proceeds normally.

Decomposition:
- lsu_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - The state encoding IDLE, RD, WR, RESP, ERR.
  - WORD_BYTES=4.
- One combinational sub-module, lsu_lane, provides both lane functions: extract+extend (word, addr[1:0], size, unsigned -> rdata) and merge (word, wdata, addr[1:0], size -> new word). The bench can unit-test it standalone.

Test Plan:
- Word store then word load at addr 0x10, data 0xDEADBEEF:
  - Store: mem_wen high for exactly one cycle with mem_adr=4 and mem_din=0xDEADBEEF.
  - Load: returns 0xDEADBEEF, resp_valid 2 cycles after accept.
- Byte store 0xA5 to addr 0x13 over an existing word 0x11223344:
  - RAM word becomes 0xA5223344.
  - Signed lb at 0x13 -> 0xFFFFFFA5; unsigned lbu -> 0x000000A5.
- Halfword store 0x8001 to addr 0x22 over 0x00000000:
  - RAM word becomes 0x80010000.
  - lh -> 0xFFFF8001; lhu -> 0x00008001.
- Error cases:
  - Word load at addr 4*DEPTH=0x200 -> resp_err=1 one cycle after accept, mem_wen never asserted.
  - req_size=11 -> resp_err=1.
  - With LSU_ALIGN_CHECK_EN, a word store at 0x06 -> error and no write. Without the macro, it writes word index 1.
- Reset mid-RMW: assert rst during WR of a byte store.
  - mem_wen falls immediately and the RAM word is unchanged.
  - All outputs return to reset values; the next request completes normally.
- Back-to-back: req_valid held high with 3 queued loads. Each is accepted only in IDLE, req_ready is low while busy, and the resp_valid pulses are spaced 3 cycles apart.
